// File: rtl/mdu_sequencer_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer and its iteration core.
package mdu_sequencer_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(XLEN);

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_e;

  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/mdu_sequencer_if.sv
// Execute-stage handshake between the pipeline (master) and the multiply/divide sequencer (slave).
interface mdu_sequencer_if import mdu_sequencer_pkg::*; ;

  logic            MduStartE;
  logic [2:0]      MduOpE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            KillE;
  logic            StallMdu;
  logic            MduValidE;
  logic [XLEN-1:0] MduResultE;
  logic            MduBusy;

  modport master (
    output MduStartE, MduOpE, SrcAE, SrcBE, KillE,
    input  StallMdu, MduValidE, MduResultE, MduBusy
  );

  modport slave (
    input  MduStartE, MduOpE, SrcAE, SrcBE, KillE,
    output StallMdu, MduValidE, MduResultE, MduBusy
  );

endinterface

// File: rtl/mdu_iter_core.sv
// Radix-2 datapath: one shift-add multiply step or one restoring-divide step per enable pulse.
module mdu_iter_core import mdu_sequencer_pkg::*; (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            en,
  input  logic            is_div,
  input  logic [XLEN-1:0] load_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] nxt_hi,
  output logic [XLEN-1:0] nxt_lo
);

  // acc holds the product high half / partial remainder; lo holds the multiplier / quotient.
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic            ge;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    acc_d   = acc_q;
    lo_d    = lo_q;
    sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, op_b} : '0);
    shifted = {acc_q, lo_q[XLEN-1]};
    ge      = shifted >= {1'b0, op_b};

    if (load) begin
      acc_d = '0;
      lo_d  = load_a;
    end else if (en) begin
      if (is_div) begin
        // The restored remainder is always below the divisor, so XLEN bits suffice.
        acc_d = ge ? (shifted[XLEN-1:0] - op_b) : shifted[XLEN-1:0];
        lo_d  = {lo_q[XLEN-2:0], ge};
      end else begin
        acc_d = sum[XLEN:1];
        lo_d  = {sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      lo_q  <= '0;
    end else begin
      acc_q <= acc_d;
      lo_q  <= lo_d;
    end
  end

  assign nxt_hi = acc_d;
  assign nxt_lo = lo_d;

endmodule

// File: rtl/mdu_sequencer.sv
// RV32M multi-cycle controller: latches operands in E, iterates XLEN cycles while stalling, then pulses a valid result.
module mdu_sequencer import mdu_sequencer_pkg::*; (
  input logic             clk,
  input logic             rst_n,
  mdu_sequencer_if.slave  mdu
);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mdu_op_e           op_q, op_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              neg_main_q, neg_main_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic              start_ok;
  mdu_op_e           in_op;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              in_div, in_rem, div_zero, div_ovf;
  logic [XLEN-1:0]   special_res;

  logic              core_load, core_en;
  logic [XLEN-1:0]   nxt_hi, nxt_lo;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   final_res;

  // Start-cycle decode: magnitudes, result signs and the two divide corner cases.
  always_comb begin
    start_ok = mdu.MduStartE & ~mdu.KillE;
    in_op    = mdu_op_e'(mdu.MduOpE);
    a_signed = in_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed = in_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    a_neg    = a_signed & mdu.SrcAE[XLEN-1];
    b_neg    = b_signed & mdu.SrcBE[XLEN-1];
    a_mag    = a_neg ? -mdu.SrcAE : mdu.SrcAE;
    b_mag    = b_neg ? -mdu.SrcBE : mdu.SrcBE;
    in_div   = in_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    in_rem   = in_op inside {OP_REM, OP_REMU};
    div_zero = in_div & (mdu.SrcBE == '0);
    div_ovf  = b_signed & in_div & (mdu.SrcAE == INT_MIN) & (mdu.SrcBE == ALL_ONES);
    if (div_zero) special_res = in_rem ? mdu.SrcAE : ALL_ONES;
    else          special_res = in_rem ? '0 : INT_MIN;
  end

  // Sign correction is taken from the core's next value so it lands on the last iteration edge.
  always_comb begin
    prod     = {nxt_hi, nxt_lo};
    prod_fix = neg_main_q ? -prod : prod;
    unique case (op_q)
      OP_MUL:                      final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             final_res = neg_main_q ? -nxt_lo : nxt_lo;
      default:                     final_res = neg_rem_q ? -nxt_hi : nxt_hi;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    b_d        = b_q;
    neg_main_d = neg_main_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    valid_d    = 1'b0;
    busy_d     = 1'b0;
    core_load  = 1'b0;
    core_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          op_d       = in_op;
          b_d        = b_mag;
          neg_main_d = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            valid_d  = 1'b1;
            state_d  = ST_DONE;
          end else begin
            core_load = 1'b1;
            cnt_d     = CNT_W'(XLEN-1);
            busy_d    = 1'b1;
            state_d   = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (mdu.KillE) begin
          state_d = ST_IDLE;
        end else begin
          core_en = 1'b1;
          if (cnt_q == '0) begin
            result_d = final_res;
            valid_d  = 1'b1;
            state_d  = ST_DONE;
          end else begin
            cnt_d  = cnt_q - 1'b1;
            busy_d = 1'b1;
          end
        end
      end
      // A start still asserted here is the same, now-completing instruction.
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_MUL;
      b_q        <= '0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      b_q        <= b_d;
      neg_main_q <= neg_main_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  mdu_iter_core u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (core_load),
    .en     (core_en),
    .is_div (op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}),
    .load_a (a_mag),
    .op_b   (b_q),
    .nxt_hi (nxt_hi),
    .nxt_lo (nxt_lo)
  );

  // The idle term is combinational so the pipeline freezes in the start cycle itself.
  assign mdu.StallMdu   = rst_n & (((state_q == ST_IDLE) & start_ok) | busy_q);
  assign mdu.MduValidE  = valid_q & ~mdu.KillE;
  assign mdu.MduResultE = result_q;
  assign mdu.MduBusy    = busy_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: stimulus queues expected results, a monitor checks each valid pulse.
module tb_mdu_sequencer;
  import mdu_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  mdu_sequencer_if bus ();

  mdu_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mdu   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.MduValidE === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_valid: got result %h with nothing outstanding", bus.MduResultE);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.name, bus.MduResultE, e.exp);
      end
    end
  end

  // Issues one instruction, holds MduStartE through DONE, and checks the stall window length.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_stall, input string name);
    int n;
    @(posedge clk); #1;
    bus.MduStartE = 1'b1;
    bus.KillE     = 1'b0;
    bus.MduOpE    = op;
    bus.SrcAE     = a;
    bus.SrcBE     = b;
    sb.push_back('{name, exp});
    n = 0;
    @(negedge clk);
    while (bus.StallMdu === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    check({name, "_valid_in_done"}, {31'd0, bus.MduValidE}, 32'd1);
  endtask

  task automatic idle_gap(input string name);
    @(posedge clk); #1;
    bus.MduStartE = 1'b0;
    bus.KillE     = 1'b0;
    @(negedge clk);
    check({name, "_gap_stall"}, {31'd0, bus.StallMdu}, 32'd0);
    check({name, "_gap_busy"},  {31'd0, bus.MduBusy},  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.MduStartE = 1'b0;
    bus.MduOpE    = 3'b000;
    bus.SrcAE     = '0;
    bus.SrcBE     = '0;
    bus.KillE     = 1'b0;
    rst_n         = 1'b0;
    #12;
    check("reset_stall",  {31'd0, bus.StallMdu},  32'd0);
    check("reset_valid",  {31'd0, bus.MduValidE}, 32'd0);
    check("reset_busy",   {31'd0, bus.MduBusy},   32'd0);
    check("reset_result", bus.MduResultE,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    start_op(OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_7_m3");    idle_gap("mul");
    start_op(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max");   idle_gap("mulhu");
    start_op(OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33, "mulhsu_m1_2"); idle_gap("mulhsu");
    start_op(OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, "div_m7_2");    idle_gap("div");
    start_op(OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, "rem_m7_2");    idle_gap("rem");
    start_op(OP_DIVU,   32'd100,        32'd7,         32'd14,        33, "divu_100_7");  idle_gap("divu");
    start_op(OP_REMU,   32'd100,        32'd7,         32'd2,         33, "remu_100_7");  idle_gap("remu");

    start_op(OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1,  "divu_by_zero"); idle_gap("divu0");
    start_op(OP_REM,    32'd5,          32'd0,         32'd5,         1,  "rem_by_zero");  idle_gap("rem0");
    start_op(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_overflow"); idle_gap("divovf");
    start_op(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  "rem_overflow"); idle_gap("removf");

    // Back-to-back: the second start lands in the IDLE cycle right after the first DONE.
    start_op(OP_MUL,    32'h0000_1234,  32'h0000_0010, 32'h0001_2340, 33, "b2b_mul");
    start_op(OP_DIV,    32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, "b2b_div");
    idle_gap("b2b");

    // Kill has priority over start in IDLE.
    @(posedge clk); #1;
    bus.MduStartE = 1'b1;
    bus.KillE     = 1'b1;
    bus.MduOpE    = OP_MUL;
    @(negedge clk);
    check("kill_idle_stall", {31'd0, bus.StallMdu}, 32'd0);
    idle_gap("kill_idle");

    // Kill during BUSY cycle 10: back to IDLE on the next edge with no result.
    @(posedge clk); #1;
    bus.MduStartE = 1'b1;
    bus.MduOpE    = OP_MUL;
    bus.SrcAE     = 32'd3;
    bus.SrcBE     = 32'd5;
    repeat (10) @(posedge clk);
    #1;
    bus.MduStartE = 1'b0;
    bus.KillE     = 1'b1;
    @(negedge clk);
    check("kill_busy_before_edge", {31'd0, bus.MduBusy}, 32'd1);
    @(posedge clk); #1;
    bus.KillE = 1'b0;
    @(negedge clk);
    check("kill_busy_stall", {31'd0, bus.StallMdu}, 32'd0);
    check("kill_busy_busy",  {31'd0, bus.MduBusy},  32'd0);
    repeat (40) @(negedge clk);

    // Kill in DONE suppresses the valid pulse.
    @(posedge clk); #1;
    bus.MduStartE = 1'b1;
    bus.MduOpE    = OP_DIVU;
    bus.SrcAE     = 32'd5;
    bus.SrcBE     = 32'd0;
    @(posedge clk); #1;
    bus.KillE = 1'b1;
    @(negedge clk);
    check("kill_done_valid", {31'd0, bus.MduValidE}, 32'd0);
    idle_gap("kill_done");

    // Asynchronous reset in the middle of BUSY.
    @(posedge clk); #1;
    bus.MduStartE = 1'b1;
    bus.MduOpE    = OP_MUL;
    bus.SrcAE     = 32'd3;
    bus.SrcBE     = 32'd5;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_stall",  {31'd0, bus.StallMdu},  32'd0);
    check("arst_busy",   {31'd0, bus.MduBusy},   32'd0);
    check("arst_valid",  {31'd0, bus.MduValidE}, 32'd0);
    check("arst_result", bus.MduResultE,         32'd0);
    bus.MduStartE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    start_op(OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh_min_min");
    idle_gap("mulh");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
